// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM engine blocks
// Contents:
//   PWM_PRESC_WIDTH_DEF   default prescaler divide/counter width
//   PWM_PRESC_DIV_RST_DEF default divide value after reset
//   presc_div_t           divide value at the default width, shared with the channel blocks
package pwm_pkg;

    localparam int PWM_PRESC_WIDTH_DEF   = 8;
    localparam int PWM_PRESC_DIV_RST_DEF = 0;

    typedef logic [PWM_PRESC_WIDTH_DEF-1:0] presc_div_t;

endpackage

// File: rtl/pwm_presc_shadow.sv
// pwm_presc_shadow: pending divide register with busy/ack handshake
// Ports:
//   clk, reset    system clock, async active-high reset
//   load, divIn   capture divIn as the pending value
//   apply         the core is at a point where a pending value may take effect
//   divPend       pending divide value
//   busy          a pending value is waiting
//   ack           one-cycle pulse after the pending value was taken
//   applied       combinational: the pending value is taken on this edge
module pwm_presc_shadow
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_PRESC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] divIn,
    input  logic             apply,
    output logic [WIDTH-1:0] divPend,
    output logic             busy,
    output logic             ack,
    output logic             applied
);

    assign applied = apply & busy;

    // A load on the application edge re-arms busy for the freshly captured value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divPend <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
        end else begin
            if (load) divPend <= divIn;
            busy <= load | (busy & ~apply);
            ack  <= applied;
        end
    end

endmodule

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: programmable clock prescaler producing a 50% divided clock and a wrap tick
// Ports:
//   clk, reset           system clock, async active-high reset
//   enable               1 = count, 0 = freeze counter and divided clock
//   div_in, div_load     requested divide value N and its capture strobe
//   div_busy, div_ack    pending value waiting / one-cycle pulse when it became active
//   clkPresc             divided clock, period 2*(N+1)
//   tick                 one-cycle strobe at each counter wrap, period N+1
//   sync_in              phase-alignment input, present only with PWM_PRESC_SYNC_EN defined
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_PRESC_WIDTH_DEF,
    parameter int DIV_RESET = PWM_PRESC_DIV_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
`ifdef PWM_PRESC_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_busy,
    output logic             div_ack,
    output logic             clkPresc,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = DIV_RESET[WIDTH-1:0];

    logic [WIDTH-1:0] cnt, cntNext, divActive, divPend;
    logic             wrap, syncEvt, apply, applied, clkNext, tickNext;

    assign wrap = cnt == divActive;

`ifdef PWM_PRESC_SYNC_EN
    logic syncQ;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) syncQ <= 1'b0;
        else       syncQ <= sync_in;
    end
    assign syncEvt = sync_in & ~syncQ;
`else
    assign syncEvt = 1'b0;
`endif

    // New ratios land only at a period boundary, while frozen, or on a sync,
    // so the divided clock never shows a runt half-period.
    assign apply = syncEvt | ~enable | wrap;

    pwm_presc_shadow #(.WIDTH(WIDTH)) shadow (
        .clk    (clk),
        .reset  (reset),
        .load   (div_load),
        .divIn  (div_in),
        .apply  (apply),
        .divPend(divPend),
        .busy   (div_busy),
        .ack    (div_ack),
        .applied(applied)
    );

    always_comb begin
        cntNext  = cnt + 1'b1;
        clkNext  = clkPresc;
        tickNext = 1'b0;
        if (syncEvt) begin
            cntNext = '0;
            clkNext = 1'b0;
        end else if (!enable) begin
            cntNext = applied ? '0 : cnt;
        end else if (wrap) begin
            cntNext  = '0;
            clkNext  = ~clkPresc;
            tickNext = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            divActive <= DIV_RST;
            clkPresc  <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt       <= cntNext;
            divActive <= applied ? divPend : divActive;
            clkPresc  <= clkNext;
            tick      <= tickNext;
        end
    end

endmodule

// File: tb/tb_pwm_prescaler.sv
// tb_pwm_prescaler: directed and randomized checks of pwm_prescaler against a period-based model
module tb_pwm_prescaler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_busy, div_ack, clkPresc, tick;
`ifdef PWM_PRESC_SYNC_EN
    logic         sync_in = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Model: current period length in cycles, cycles elapsed in it, pending value.
    int period, elapsed, pend;
    bit busyM, clkM, tickM, ackM;

    always #5 clk = ~clk;

    pwm_prescaler #(.WIDTH(W), .DIV_RESET(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .div_in  (div_in),
        .div_load(div_load),
`ifdef PWM_PRESC_SYNC_EN
        .sync_in (sync_in),
`endif
        .div_busy(div_busy),
        .div_ack (div_ack),
        .clkPresc(clkPresc),
        .tick    (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        period = 4;
        elapsed = 0;
        pend = 0;
        busyM = 0;
        clkM = 0;
        tickM = 0;
        ackM = 0;
    endtask

    // One clock edge of the spec: a period of N+1 enabled cycles ends with a tick and a
    // half-period flip; a waiting value takes over at a period end or whenever frozen.
    task automatic modelStep(input bit en, input bit ld, input int din);
        bit periodEnd, take;
        periodEnd = en && (elapsed + 1 == period);
        take = busyM && (!en || periodEnd);
        tickM = periodEnd;
        ackM = take;
        if (periodEnd) clkM = !clkM;
        if (en) elapsed = periodEnd ? 0 : elapsed + 1;
        else if (take) elapsed = 0;
        if (take) period = pend + 1;
        if (ld) pend = din;
        busyM = ld || (busyM && !take);
    endtask

    task automatic step(input bit en, input bit ld, input logic [W-1:0] din);
        enable = en;
        div_load = ld;
        div_in = din;
        @(posedge clk);
        modelStep(en, ld, int'(din));
        #1;
        check("tick", tick, tickM);
        check("clkPresc", clkPresc, clkM);
        check("div_busy", div_busy, busyM);
        check("div_ack", div_ack, ackM);
    endtask

    // Runs enabled cycles until an ack is seen; returns the number of steps or -1.
    task automatic runUntilAck(output int n);
        n = -1;
        for (int i = 1; i <= 60 && n < 0; i++) begin
            step(1, 0, 0);
            if (div_ack) n = i;
        end
    endtask

    task automatic runUntilTick(output int n);
        n = -1;
        for (int i = 1; i <= 60 && n < 0; i++) begin
            step(1, 0, 0);
            if (tick) n = i;
        end
    endtask

    initial begin
        int n, firstTick, rise1, rise2, acks, frozen;
        bit prevClk;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_tick", tick, 0);
        check("rst_clkPresc", clkPresc, 0);
        check("rst_busy", div_busy, 0);
        check("rst_ack", div_ack, 0);
        reset = 1'b0;

        // DIV_RESET=3: tick every 4 cycles, clkPresc period 8, first rise after 4 edges
        firstTick = -1; rise1 = -1; rise2 = -1; prevClk = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (tick && firstTick < 0) firstTick = i;
            if (clkPresc && !prevClk) begin
                if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
            end
            prevClk = clkPresc;
        end
        check("first_tick", firstTick, 4);
        check("first_rise", rise1, 4);
        check("clk_period", rise2 - rise1, 8);

        // N=0: clk/2 and tick held high
        step(1, 1, 0);
        runUntilAck(n);
        check("n0_ack_seen", n > 0, 1);
        prevClk = clkPresc;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            check("n0_tick_high", tick, 1);
            check("n0_toggle", clkPresc, !prevClk);
            prevClk = clkPresc;
        end

        // N=9, then load N=2 at cnt=4: old period completes first
        step(1, 1, 9);
        runUntilAck(n);
        check("n9_ack_seen", n > 0, 1);
        repeat (4) step(1, 0, 0);
        step(1, 1, 2);
        runUntilAck(n);
        check("n9_to_n2_ack_delay", n, 5);
        check("ack_on_wrap", tick, 1);
        runUntilTick(n);
        check("n2_tick_gap", n, 3);

        // Two loads in one period: last wins, single ack
        step(1, 1, 5);
        step(1, 1, 7);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0);
            acks += int'(div_ack);
        end
        check("double_load_acks", acks, 1);
        runUntilTick(n);
        runUntilTick(n);
        check("last_wins_period", n, 8);

        // Freeze mid-period; a load while frozen applies on the next cycle
        repeat (3) step(1, 0, 0);
        frozen = int'(clkPresc);
        step(0, 1, 4);
        check("frozen_busy", div_busy, 1);
        for (int i = 1; i < 20; i++) begin
            step(0, 0, 0);
            if (i == 1) check("frozen_ack", div_ack, 1);
            check("frozen_tick", tick, 0);
            check("frozen_clk", clkPresc, frozen);
        end
        runUntilTick(n);
        check("resume_from_zero", n, 5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, W'($urandom_range(0, 12)));

        // Reset mid-period while a value is pending
        step(1, 1, 9);
        runUntilAck(n);
        repeat (3) step(1, 0, 0);
        step(1, 1, 6);
        check("pre_reset_busy", div_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_tick", tick, 0);
        check("async_clkPresc", clkPresc, 0);
        check("async_busy", div_busy, 0);
        check("async_ack", div_ack, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
        acks = 0; firstTick = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            acks += int'(div_ack);
            if (tick && firstTick < 0) firstTick = i;
        end
        check("post_reset_no_ack", acks, 0);
        check("post_reset_div", firstTick, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
